// File: rtl/qrd_stream_ctrl_if.sv
// Stream bundle for qrd_stream_ctrl: H element input
// on the s_* side, R/QH result output on the m_* side.
interface qrd_stream_ctrl_if #(
  parameter int W = 14
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data_r;
  logic [W-1:0] s_data_i;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data_r;
  logic [W-1:0] m_data_i;
  logic         m_sel;
  logic         m_last;

  modport slave (
    input  s_valid, s_data_r, s_data_i, m_ready,
    output s_ready, m_valid, m_data_r, m_data_i,
    output m_sel, m_last
  );

  modport master (
    output s_valid, s_data_r, s_data_i, m_ready,
    input  s_ready, m_valid, m_data_r, m_data_i,
    input  m_sel, m_last
  );
endinterface

// File: rtl/qrd_stream_ctrl.sv
// Sequencer between a row-major matrix stream and a
// 4x4 systolic QRD core: feeds skewed [H|I], replays R then QH.
module qrd_stream_ctrl #(
  parameter int N   = 4,
  parameter int W   = 14,
  parameter int ONE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  qrd_stream_ctrl_if.slave bus,
  input  logic          core_in_ready,
  output logic [W-1:0]  row_in_1_r,
  output logic [W-1:0]  row_in_1_i,
  output logic [W-1:0]  row_in_2_r,
  output logic [W-1:0]  row_in_2_i,
  output logic [W-1:0]  row_in_3_r,
  output logic [W-1:0]  row_in_3_i,
  output logic [W-1:0]  row_in_4_r,
  output logic [W-1:0]  row_in_4_i,
  output logic          row_in_1_f,
  output logic          row_in_2_f,
  output logic          row_in_3_f,
  input  logic          core_out_valid,
  input  logic [W-1:0]  row_out_1_r,
  input  logic [W-1:0]  row_out_1_i,
  input  logic [W-1:0]  row_out_2_r,
  input  logic [W-1:0]  row_out_2_i,
  input  logic [W-1:0]  row_out_3_r,
  input  logic [W-1:0]  row_out_3_i,
  input  logic [W-1:0]  row_out_4_r,
  input  logic [W-1:0]  row_out_4_i,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FEED = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0] beat;
  logic [3:0] step;
  logic [4:0] ocnt;
  logic [2:0] flag, flag_n;

  logic [W-1:0] hb_r [N][N];
  logic [W-1:0] hb_i [N][N];
  logic [W-1:0] rr_r [N][N];
  logic [W-1:0] rr_i [N][N];
  logic [W-1:0] qh_r [N][N];
  logic [W-1:0] qh_i [N][N];

  logic [W-1:0] lane_r  [N];
  logic [W-1:0] lane_i  [N];
  logic [W-1:0] lane_nr [N];
  logic [W-1:0] lane_ni [N];
  logic [W-1:0] out_r   [N];
  logic [W-1:0] out_i   [N];
  logic [3:0]   col     [N];
  logic [3:0]   rel_r   [N];
  logic [3:0]   rel_q   [N];

  logic s_rdy, s_acc, step_acc, m_vld, m_acc, m_lst;

  assign out_r[0] = row_out_1_r;
  assign out_i[0] = row_out_1_i;
  assign out_r[1] = row_out_2_r;
  assign out_i[1] = row_out_2_i;
  assign out_r[2] = row_out_3_r;
  assign out_i[2] = row_out_3_i;
  assign out_r[3] = row_out_4_r;
  assign out_i[3] = row_out_4_i;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_rdy     = (state == LOAD) && !rst;
    m_vld     = (state == OUT);
    m_lst     = (state == OUT) && (ocnt == 5'd31);
    s_acc     = bus.s_valid && s_rdy;
    step_acc  = (state == FEED) && core_in_ready;
    m_acc     = m_vld && bus.m_ready;
    unique case (state)
      LOAD: if (s_acc && beat == 4'd15)    state_nxt = FEED;
      FEED: if (step_acc && step == 4'd15) state_nxt = OUT;
      OUT:  if (m_acc && m_lst)            state_nxt = LOAD;
      default:                             state_nxt = LOAD;
    endcase
  end

  // Lane k is skewed by k steps; columns 4..7 form the identity
  always_comb begin
    for (int k = 0; k < N; k++) begin
      col[k]     = step - 4'(k);
      rel_r[k]   = step - 4'(5 + k);
      rel_q[k]   = step - 4'(9 + k);
      lane_nr[k] = '0;
      lane_ni[k] = '0;
      if (!col[k][3]) begin
        if (!col[k][2]) begin
          lane_nr[k] = hb_r[k][col[k][1:0]];
          lane_ni[k] = hb_i[k][col[k][1:0]];
        end else if (col[k][1:0] == 2'(k)) begin
          lane_nr[k] = W'(ONE);
        end
      end
    end
    flag_n = {step == 4'd4, step == 4'd2, step == 4'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
      step <= '0;
      ocnt <= '0;
      flag <= '0;
      err  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        lane_r[k] <= '0;
        lane_i[k] <= '0;
      end
    end else begin
      if (s_acc) beat <= beat + 4'd1;
      if (step_acc) begin
        if (step >= 4'd5 && !core_out_valid) err <= 1'b1;
        lane_r <= lane_nr;
        lane_i <= lane_ni;
        flag   <= flag_n;
        step   <= step + 4'd1;
      end
      if (m_acc) begin
        ocnt <= ocnt + 5'd1;
        if (m_lst) err <= 1'b0;
      end
    end
  end

  // Buffers carry no reset: contents are dead until rewritten
  always_ff @(posedge clk) begin
    if (s_acc) begin
      hb_r[beat[3:2]][beat[1:0]] <= bus.s_data_r;
      hb_i[beat[3:2]][beat[1:0]] <= bus.s_data_i;
    end
    if (step_acc) begin
      for (int j = 0; j < N; j++) begin
        if (rel_r[j][3:2] == 2'd0) begin
          rr_r[j][rel_r[j][1:0]] <= out_r[j];
          rr_i[j][rel_r[j][1:0]] <= out_i[j];
        end
        if (rel_q[j][3:2] == 2'd0) begin
          qh_r[j][rel_q[j][1:0]] <= out_r[j];
          qh_i[j][rel_q[j][1:0]] <= out_i[j];
        end
      end
    end
  end

  always_comb begin
    bus.m_data_r = '0;
    bus.m_data_i = '0;
    if (m_vld) begin
      if (ocnt[4]) begin
        bus.m_data_r = qh_r[ocnt[3:2]][ocnt[1:0]];
        bus.m_data_i = qh_i[ocnt[3:2]][ocnt[1:0]];
      end else begin
        bus.m_data_r = rr_r[ocnt[3:2]][ocnt[1:0]];
        bus.m_data_i = rr_i[ocnt[3:2]][ocnt[1:0]];
      end
    end
  end

  assign bus.s_ready = s_rdy;
  assign bus.m_valid = m_vld;
  assign bus.m_sel   = m_vld && ocnt[4];
  assign bus.m_last  = m_lst;
  assign busy        = (state != LOAD);

  assign row_in_1_r = lane_r[0];
  assign row_in_1_i = lane_i[0];
  assign row_in_2_r = lane_r[1];
  assign row_in_2_i = lane_i[1];
  assign row_in_3_r = lane_r[2];
  assign row_in_3_i = lane_i[2];
  assign row_in_4_r = lane_r[3];
  assign row_in_4_i = lane_i[3];
  assign row_in_1_f = flag[0];
  assign row_in_2_f = flag[1];
  assign row_in_3_f = flag[2];

endmodule

// File: tb/tb_qrd_stream_ctrl.sv
// Bench for qrd_stream_ctrl: directed matrices through a
// stub core that echoes the feed step index on its lanes.
`timescale 1ns/1ps
module tb_qrd_stream_ctrl;
  localparam int W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qrd_stream_ctrl_if #(.W(W)) sif();

  logic         core_in_ready = 1'b0;
  logic         core_out_valid = 1'b0;
  logic [W-1:0] ri_r [4];
  logic [W-1:0] ri_i [4];
  logic [W-1:0] ro_r [4];
  logic [W-1:0] ro_i [4];
  logic         f1, f2, f3;
  logic         err, busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] hr [4][4];
  logic [W-1:0] hi [4][4];
  bit aborted;

  qrd_stream_ctrl #(.N(4), .W(W), .ONE(1024)) dut (
    .clk(clk), .rst(rst), .bus(sif),
    .core_in_ready(core_in_ready),
    .row_in_1_r(ri_r[0]), .row_in_1_i(ri_i[0]),
    .row_in_2_r(ri_r[1]), .row_in_2_i(ri_i[1]),
    .row_in_3_r(ri_r[2]), .row_in_3_i(ri_i[2]),
    .row_in_4_r(ri_r[3]), .row_in_4_i(ri_i[3]),
    .row_in_1_f(f1), .row_in_2_f(f2), .row_in_3_f(f3),
    .core_out_valid(core_out_valid),
    .row_out_1_r(ro_r[0]), .row_out_1_i(ro_i[0]),
    .row_out_2_r(ro_r[1]), .row_out_2_i(ro_i[1]),
    .row_out_3_r(ro_r[2]), .row_out_3_i(ro_i[2]),
    .row_out_4_r(ro_r[3]), .row_out_4_i(ro_i[3]),
    .err(err), .busy(busy)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_r(input int k,
                                         input int l);
    int c;
    c = l - k;
    if (c < 0 || c > 7) return '0;
    if (c < 4) return hr[k][c];
    return (c - 4 == k) ? W'(1024) : '0;
  endfunction

  function automatic logic [W-1:0] exp_i(input int k,
                                         input int l);
    int c;
    c = l - k;
    if (c < 0 || c > 3) return '0;
    return hi[k][c];
  endfunction

  task automatic chk_lanes(input string tag, input int l);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s%0d_r@%0d", tag, k + 1, l),
            ri_r[k], exp_r(k, l));
      check($sformatf("%s%0d_i@%0d", tag, k + 1, l),
            ri_i[k], exp_i(k, l));
    end
    check($sformatf("%s_f1@%0d", tag, l), f1, int'(l == 0));
    check($sformatf("%s_f2@%0d", tag, l), f2, int'(l == 2));
    check($sformatf("%s_f3@%0d", tag, l), f3, int'(l == 4));
  endtask

  task automatic load(input int p);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        if (p == 0) begin
          hr[i][j] = (i == j) ? W'(512) : '0;
          hi[i][j] = '0;
        end else begin
          hr[i][j] = W'(p * 211 + i * 97 - j * 301 - 500);
          hi[i][j] = W'(p * 13 - i * 40 + j * 7);
        end
      end
    for (int b = 0; b < 16; b++) begin
      int g;
      sif.s_valid  = 1'b1;
      sif.s_data_r = hr[b / 4][b % 4];
      sif.s_data_i = hi[b / 4][b % 4];
      g = 0;
      while (!sif.s_ready && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
      check($sformatf("load_s_ready@%0d", b), sif.s_ready, 1);
      @(posedge clk); #1;
    end
    sif.s_valid = 1'b0;
    check("load_busy", busy, 1);
    check("load_s_ready_off", sif.s_ready, 0);
  endtask

  task automatic feed(input int stall_at, input int cov_low_at,
                      input int rst_at, output bit ab);
    ab = 1'b0;
    for (int l = 0; l < 16; l++) begin
      if (l == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_s_ready", sif.s_ready, 1);
        check("rst_m_valid", sif.m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        for (int k = 0; k < 4; k++) begin
          check($sformatf("rst_lane%0d_r", k + 1), ri_r[k], 0);
          check($sformatf("rst_lane%0d_i", k + 1), ri_i[k], 0);
        end
        check("rst_flags", {f3, f2, f1}, 0);
        ab = 1'b1;
        return;
      end
      if (l == stall_at) begin
        core_in_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk_lanes("stall", l - 1);
        end
      end
      core_in_ready  = 1'b1;
      core_out_valid = (l != cov_low_at);
      for (int k = 0; k < 4; k++) begin
        ro_r[k] = W'(l);
        ro_i[k] = W'(16 * (k + 1) + l);
      end
      @(posedge clk); #1;
      core_in_ready  = 1'b0;
      core_out_valid = 1'b0;
      chk_lanes("lane", l);
    end
    check("first_m_valid", sif.m_valid, 1);
  endtask

  task automatic drain(input bit toggle, input bit exp_err);
    int b, cyc;
    b = 0;
    cyc = 0;
    while (b < 32 && cyc < 200) begin
      int sel, row, cl, er;
      sel = b / 16;
      row = (b % 16) / 4;
      cl  = b % 4;
      er  = (sel != 0 ? 9 : 5) + row + cl;
      sif.m_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      check($sformatf("m_valid@%0d", b), sif.m_valid, 1);
      check($sformatf("m_data_r@%0d", b), sif.m_data_r, er);
      check($sformatf("m_data_i@%0d", b), sif.m_data_i,
            16 * (row + 1) + er);
      check($sformatf("m_sel@%0d", b), sif.m_sel, sel);
      check($sformatf("m_last@%0d", b), sif.m_last,
            int'(b == 31));
      check($sformatf("out_s_ready@%0d", b), sif.s_ready, 0);
      check($sformatf("out_err@%0d", b), err, int'(exp_err));
      @(posedge clk); #1;
      if (sif.m_ready) b++;
      cyc++;
    end
    sif.m_ready = 1'b0;
    check("drain_beats", b, 32);
    check("done_m_valid", sif.m_valid, 0);
    check("done_busy", busy, 0);
    check("done_err", err, 0);
    check("done_s_ready", sif.s_ready, 1);
  endtask

  initial begin
    sif.s_valid  = 1'b0;
    sif.s_data_r = '0;
    sif.s_data_i = '0;
    sif.m_ready  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ro_r[k] = '0;
      ro_i[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_s_ready", sif.s_ready, 0);
    check("reset_m_valid", sif.m_valid, 0);
    check("reset_m_last", sif.m_last, 0);
    check("reset_m_data_r", sif.m_data_r, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_lane1_r", ri_r[0], 0);
    check("reset_flags", {f3, f2, f1}, 0);
    rst = 1'b0;
    #1;
    check("idle_s_ready", sif.s_ready, 1);

    load(0);
    feed(-1, -1, -1, aborted);
    drain(1'b0, 1'b0);

    load(1);
    feed(6, -1, -1, aborted);
    drain(1'b1, 1'b0);

    load(2);
    feed(-1, 7, -1, aborted);
    drain(1'b0, 1'b1);

    load(3);
    feed(-1, -1, 9, aborted);
    load(4);
    feed(-1, -1, -1, aborted);
    drain(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
